// File: rtl/fwd_rb_pkg.sv
// rtl/fwd_rb_pkg.sv - default sizes and forwarding-source encoding for the operand register bank
package fwd_rb_pkg;

  localparam int DATA_W_DEF   = 16;
  localparam int NUM_REGS_DEF = 32;
  localparam int ADDR_W_DEF   = 5;

  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_EX,
    SRC_DM,
    SRC_WB,
    SRC_RF
  } fwd_src_e;

endpackage

// File: rtl/fwd_src_sel.sv
// rtl/fwd_src_sel.sv - per-port operand source resolver (zero / EX / DM / WB / register file)
// EX and DM forwarding are active only when RF_FWD_EN is defined; WB bypass is always kept.
module fwd_src_sel
  import fwd_rb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_ans,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_rd,
  input  logic [DATA_W-1:0] dm_ans,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_ans,
  input  logic [DATA_W-1:0] rf_data,
  output logic [DATA_W-1:0] data,
  output logic              ex_match,
  output logic              dm_match
);

  fwd_src_e src;
  logic     zero_hit;
  logic     wb_match;

  // The zero register never matches a producer, so it can neither forward nor stall.
  assign zero_hit = (ZERO_REG != 0) && (addr == '0);
  assign ex_match = ex_we && (ex_rd == addr) && !zero_hit;
  assign dm_match = dm_we && (dm_rd == addr) && !zero_hit;
  assign wb_match = wb_we && (wb_rd == addr);

`ifndef RF_FWD_EN
  logic unused_load;
  assign unused_load = ex_is_load;
`endif

  always_comb begin
    src = SRC_RF;
    if (zero_hit)
      src = SRC_ZERO;
`ifdef RF_FWD_EN
    else if (ex_match && !ex_is_load)
      src = SRC_EX;
    else if (dm_match)
      src = SRC_DM;
`endif
    else if (wb_match)
      src = SRC_WB;
  end

  always_comb begin
    data = rf_data;
    case (src)
      SRC_ZERO: data = '0;
      SRC_EX:   data = ex_ans;
      SRC_DM:   data = dm_ans;
      SRC_WB:   data = wb_ans;
      default:  data = rf_data;
    endcase
  end

endmodule

// File: rtl/fwd_reg_bank.sv
// rtl/fwd_reg_bank.sv - register file with internal forwarding, load-use detection and operand latch
// Optional macro RF_FWD_EN enables EX/DM forwarding; without it any EX/DM match requests a stall.
module fwd_reg_bank
  import fwd_rb_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              ex_we,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic              ex_is_load,
  input  logic [DATA_W-1:0] ex_ans,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_rd,
  input  logic [DATA_W-1:0] dm_ans,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_rd,
  input  logic [DATA_W-1:0] wb_ans,
  input  logic              hold,
  input  logic              flush,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic              load_use_stall
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;
  logic [DATA_W-1:0] rf_a, rf_b, res_a, res_b;
  logic              a_ex_match, a_dm_match, b_ex_match, b_dm_match;

  assign wr_en = wb_we && !((ZERO_REG != 0) && (wb_rd == '0))
               && ({{(32-ADDR_W){1'b0}}, wb_rd} < 32'(NUM_REGS));

  // Out-of-range addresses read as zero.
  assign rf_a = ({{(32-ADDR_W){1'b0}}, ra} < 32'(NUM_REGS)) ? regs[ra] : '0;
  assign rf_b = ({{(32-ADDR_W){1'b0}}, rb} < 32'(NUM_REGS)) ? regs[rb] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wr_en) begin
      regs[wb_rd] <= wb_ans;
    end
  end

  fwd_src_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_a (
    .addr(ra), .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_ans(ex_ans),
    .dm_we(dm_we), .dm_rd(dm_rd), .dm_ans(dm_ans),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_ans(wb_ans),
    .rf_data(rf_a), .data(res_a), .ex_match(a_ex_match), .dm_match(a_dm_match)
  );

  fwd_src_sel #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(ZERO_REG)) u_sel_b (
    .addr(rb), .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_ans(ex_ans),
    .dm_we(dm_we), .dm_rd(dm_rd), .dm_ans(dm_ans),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_ans(wb_ans),
    .rf_data(rf_b), .data(res_b), .ex_match(b_ex_match), .dm_match(b_dm_match)
  );

  // Operand B only creates a hazard when it is actually read from a register.
`ifdef RF_FWD_EN
  logic unused_dm;
  assign unused_dm = a_dm_match ^ b_dm_match;
  assign load_use_stall = ex_is_load && (a_ex_match || (!imm_sel && b_ex_match));
`else
  assign load_use_stall = (a_ex_match || a_dm_match)
                        || (!imm_sel && (b_ex_match || b_dm_match));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a <= '0;
      b <= '0;
    end else if (flush) begin
      a <= '0;
      b <= '0;
    end else if (!(hold || load_use_stall)) begin
      a <= res_a;
      b <= imm_sel ? imm : res_b;
    end
  end

endmodule

// File: tb/tb_fwd_reg_bank.sv
// tb/tb_fwd_reg_bank.sv - directed vector bench for fwd_reg_bank; expectations follow RF_FWD_EN
module tb_fwd_reg_bank;

`ifdef RF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  ra, rb, ex_rd, dm_rd, wb_rd;
  logic [15:0] imm, ex_ans, dm_ans, wb_ans;
  logic        imm_sel, ex_we, ex_is_load, dm_we, wb_we, hold, flush;
  logic [15:0] a, b;
  logic        load_use_stall;

  int checks = 0;
  int errors = 0;

  fwd_reg_bank dut (
    .clk(clk), .rst_n(rst_n), .ra(ra), .rb(rb), .imm(imm), .imm_sel(imm_sel),
    .ex_we(ex_we), .ex_rd(ex_rd), .ex_is_load(ex_is_load), .ex_ans(ex_ans),
    .dm_we(dm_we), .dm_rd(dm_rd), .dm_ans(dm_ans),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_ans(wb_ans),
    .hold(hold), .flush(flush), .a(a), .b(b), .load_use_stall(load_use_stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  ra, rb;
    logic        isel;
    logic [15:0] imm;
    logic        exwe;
    logic [4:0]  exrd;
    logic        exld;
    logic [15:0] exans;
    logic        dmwe;
    logic [4:0]  dmrd;
    logic [15:0] dmans;
    logic        wbwe;
    logic [4:0]  wbrd;
    logic [15:0] wbans;
    logic        hold, flush;
    logic [15:0] af, bf;
    logic        sf;
    logic [15:0] an, bn;
    logic        sn;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [4:0] i_ra, input logic [4:0] i_rb, input logic i_isel, input logic [15:0] i_imm,
    input logic i_exwe, input logic [4:0] i_exrd, input logic i_exld, input logic [15:0] i_exans,
    input logic i_dmwe, input logic [4:0] i_dmrd, input logic [15:0] i_dmans,
    input logic i_wbwe, input logic [4:0] i_wbrd, input logic [15:0] i_wbans,
    input logic i_hold, input logic i_flush,
    input logic [15:0] i_af, input logic [15:0] i_bf, input logic i_sf,
    input logic [15:0] i_an, input logic [15:0] i_bn, input logic i_sn);
    vec_t v;
    v.ra = i_ra; v.rb = i_rb; v.isel = i_isel; v.imm = i_imm;
    v.exwe = i_exwe; v.exrd = i_exrd; v.exld = i_exld; v.exans = i_exans;
    v.dmwe = i_dmwe; v.dmrd = i_dmrd; v.dmans = i_dmans;
    v.wbwe = i_wbwe; v.wbrd = i_wbrd; v.wbans = i_wbans;
    v.hold = i_hold; v.flush = i_flush;
    v.af = i_af; v.bf = i_bf; v.sf = i_sf;
    v.an = i_an; v.bn = i_bn; v.sn = i_sn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ra = '0; rb = '0; imm = '0; imm_sel = 1'b0;
    ex_we = 1'b0; ex_rd = '0; ex_is_load = 1'b0; ex_ans = '0;
    dm_we = 1'b0; dm_rd = '0; dm_ans = '0;
    wb_we = 1'b0; wb_rd = '0; wb_ans = '0;
    hold = 1'b0; flush = 1'b0;
  endtask

  initial begin
    //        ra rb is imm       exwe rd ld ans        dmwe rd ans        wbwe rd ans        hd fl  fwd: a b stall               nofwd: a b stall
    vecs.push_back(mk(1, 2, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 7, 16'hE000, 0, 0, 16'h0,    16'h0,    0, 16'h0,    16'h0,    0));
    vecs.push_back(mk(7, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'hE000, 16'h0,    0, 16'hE000, 16'h0,    0));
    vecs.push_back(mk(5, 6, 0, 16'h0,    1, 5, 0, 16'hC000, 1, 6, 16'hD000, 0, 0, 16'h0,    0, 0, 16'hC000, 16'hD000, 0, 16'hE000, 16'h0,    1));
    vecs.push_back(mk(5, 6, 0, 16'h0,    1, 5, 0, 16'hC000, 1, 5, 16'hD000, 0, 0, 16'h0,    0, 0, 16'hC000, 16'h0,    0, 16'hE000, 16'h0,    1));
    vecs.push_back(mk(3, 6, 1, 16'hFFFF, 1, 6, 0, 16'h1111, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'hFFFF, 0, 16'h0,    16'hFFFF, 0));
    vecs.push_back(mk(3, 6, 1, 16'hFFFF, 1, 6, 1, 16'h1111, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'hFFFF, 0, 16'h0,    16'hFFFF, 0));
    vecs.push_back(mk(5, 7, 0, 16'h0,    1, 5, 1, 16'hC000, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'hFFFF, 1, 16'h0,    16'hFFFF, 1));
    vecs.push_back(mk(5, 7, 0, 16'h0,    1, 5, 0, 16'hC000, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'hC000, 16'hE000, 0, 16'h0,    16'hFFFF, 1));
    vecs.push_back(mk(9, 9, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 9, 16'hABCD, 0, 0, 16'hABCD, 16'hABCD, 0, 16'hABCD, 16'hABCD, 0));
    vecs.push_back(mk(9, 7, 0, 16'h0,    0, 0, 0, 16'h0,    1, 9, 16'h5555, 1, 9, 16'h6666, 0, 0, 16'h5555, 16'hE000, 0, 16'hABCD, 16'hABCD, 1));
    vecs.push_back(mk(0, 0, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 16'h1234, 0, 0, 16'h0,    16'h0,    0, 16'h0,    16'h0,    0));
    vecs.push_back(mk(0, 9, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'h6666, 0, 16'h0,    16'h6666, 0));
    vecs.push_back(mk(7, 7, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    1, 0, 16'h0,    16'h6666, 0, 16'h0,    16'h6666, 0));
    vecs.push_back(mk(7, 7, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    1, 1, 16'h0,    16'h0,    0, 16'h0,    16'h0,    0));
    vecs.push_back(mk(0, 7, 0, 16'h0,    1, 0, 1, 16'h9999, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    16'hE000, 0, 16'h0,    16'hE000, 0));
    vecs.push_back(mk(5, 7, 0, 16'h0,    1, 5, 1, 16'hC000, 0, 0, 16'h0,    0, 0, 16'h0,    0, 1, 16'h0,    16'h0,    1, 16'h0,    16'h0,    1));
    vecs.push_back(mk(4, 4, 0, 16'h0,    1, 4, 0, 16'h1A1A, 1, 4, 16'h2B2B, 1, 4, 16'h3C3C, 0, 0, 16'h1A1A, 16'h1A1A, 0, 16'h0,    16'h0,    1));
    vecs.push_back(mk(4, 9, 0, 16'h0,    0, 0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h0,    0, 0, 16'h3C3C, 16'h6666, 0, 16'h3C3C, 16'h6666, 0));

    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_a", a, 16'h0);
    chk("reset_b", b, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      ra = vecs[i].ra; rb = vecs[i].rb; imm_sel = vecs[i].isel; imm = vecs[i].imm;
      ex_we = vecs[i].exwe; ex_rd = vecs[i].exrd; ex_is_load = vecs[i].exld; ex_ans = vecs[i].exans;
      dm_we = vecs[i].dmwe; dm_rd = vecs[i].dmrd; dm_ans = vecs[i].dmans;
      wb_we = vecs[i].wbwe; wb_rd = vecs[i].wbrd; wb_ans = vecs[i].wbans;
      hold = vecs[i].hold; flush = vecs[i].flush;
      #1;
      chk($sformatf("v%0d_stall", i), {15'h0, load_use_stall}, {15'h0, FWD ? vecs[i].sf : vecs[i].sn});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_a", i), a, FWD ? vecs[i].af : vecs[i].an);
      chk($sformatf("v%0d_b", i), b, FWD ? vecs[i].bf : vecs[i].bn);
    end

    // Asynchronous reset between edges, with a WB write pending across a held-reset edge.
    @(negedge clk);
    clear_inputs();
    ra = 5'd7; rb = 5'd7;
    @(posedge clk);
    #1;
    chk("pre_rst_a", a, 16'hE000);
    chk("pre_rst_b", b, 16'hE000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_a", a, 16'h0);
    chk("async_rst_b", b, 16'h0);
    wb_we = 1'b1; wb_rd = 5'd7; wb_ans = 16'hFFFF;
    @(posedge clk);
    #1;
    chk("rst_held_a", a, 16'h0);
    @(negedge clk);
    wb_we = 1'b0;
    rst_n = 1'b1;

    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      ra = 5'(r); rb = 5'(r);
      @(posedge clk);
      #1;
      chk($sformatf("post_rst_r%0d_a", r), a, 16'h0);
      chk($sformatf("post_rst_r%0d_b", r), b, 16'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
